// File: rtl/datapath.sv
// -----------------------------------------------------------------------------
// datapath -- single-bus 32-bit processor datapath
//
// One shared 32-bit bus feeds every register. Control inputs pick which source
// drives the bus and which registers load it on the next rising clock edge.
// All registers load from the pre-edge bus value, so any number of loads can
// happen on the same edge.
//
// Configuration macro: DATAPATH_RAM_EN
//   defined   : internal 512x32 RAM addressed by MAR. MDR_read returns
//               RAM[MAR] and RAM_write stores MDR into RAM[MAR]. Mdatain is
//               ignored.
//   undefined : no RAM. MDR_read returns Mdatain and RAM_write is ignored.
//
// Ports
//   clk             rising-edge clock
//   clr             asynchronous active-high reset of all registers (not RAM)
//   OutPort_output  output-port register
//   branch_flag     CON flip-flop
//   IncPC           ALU forced to bus+1 (overrides opCode)
//   CONin           CON flip-flop load
//   Mdatain         external memory read data
//   opCode          ALU operation select
//   RAM_write       store MDR into RAM[MAR]
//   MDR_enable      MDR load; MDR_read picks memory data instead of the bus
//   MDRout          MDR drives the bus
//   MAR_enable      MAR load (bus[8:0])
//   IR_enable       IR load
//   Gra/Grb/Grc     select IR fields Ra/Rb/Rc as the register index
//   HI_enable, LO_enable, Y_enable, PC_enable, OutPort_enable  register loads
//   ZHighIn/ZLowIn  load upper/lower word of the 64-bit ALU result into Z
//   InPortout, PCout, Yout, ZLowout, ZHighout, LOout, HIout, Cout  bus drives
//   BAout           selected register drives the bus, R0 reads as zero
//   R_in, R_out     load / drive the selected general register
//   InPort_input    input-port pins, sampled on every edge
//   Cin             carry-in, added only by ADD
// -----------------------------------------------------------------------------
module datapath (
  input  logic        clk,
  input  logic        clr,
  output logic [31:0] OutPort_output,
  output logic        branch_flag,
  input  logic        IncPC,
  input  logic        CONin,
  input  logic [31:0] Mdatain,
  input  logic [4:0]  opCode,
  input  logic        RAM_write,
  input  logic        MDR_enable,
  input  logic        MDRout,
  input  logic        MAR_enable,
  input  logic        IR_enable,
  input  logic        MDR_read,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        HI_enable,
  input  logic        LO_enable,
  input  logic        ZHighIn,
  input  logic        ZLowIn,
  input  logic        Y_enable,
  input  logic        PC_enable,
  input  logic        OutPort_enable,
  input  logic        InPortout,
  input  logic        PCout,
  input  logic        Yout,
  input  logic        ZLowout,
  input  logic        ZHighout,
  input  logic        LOout,
  input  logic        HIout,
  input  logic        BAout,
  input  logic        Cout,
  input  logic [31:0] InPort_input,
  input  logic        R_in,
  input  logic        R_out,
  input  logic        Cin
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;

  // Architectural state
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] y_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] mdr_q;
  logic [31:0] inport_q;
  logic [31:0] outport_q;
  logic [63:0] z_q;
  logic [8:0]  mar_q;
  logic        con_q;
  logic [31:0] rf_q [16];

  // Combinational values
  logic [31:0] bus_s;
  logic [3:0]  rsel_s;
  logic [31:0] rf_rd_s;
  logic [31:0] csext_s;
  logic [31:0] mem_rd_s;
  logic [4:0]  shamt_s;
  logic [63:0] dbl_s;
  logic [63:0] ror_full_s;
  logic [63:0] rol_full_s;
  logic [31:0] sra_s;
  logic [63:0] mul_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [63:0] z_d;
  logic [31:0] mdr_d;
  logic        con_d;
  logic        unused_bits_s;

  // The index fields of the enabled selectors are ORed together; normally
  // only one of Gra/Grb/Grc is asserted at a time.
  assign rsel_s  = ({4{Gra}} & ir_q[26:23])
                 | ({4{Grb}} & ir_q[22:19])
                 | ({4{Grc}} & ir_q[18:15]);

  assign csext_s = {{13{ir_q[18]}}, ir_q[18:0]};

  // Register-file read port; BAout treats R0 as a hard zero (base-address use).
  always_comb begin
    rf_rd_s = rf_q[rsel_s];
    if (BAout && (rsel_s == 4'd0)) begin
      rf_rd_s = 32'd0;
    end else begin
      rf_rd_s = rf_q[rsel_s];
    end
  end

  // Bus source multiplexer, fixed priority from PCout down to R_out/BAout.
  always_comb begin
    bus_s = 32'd0;
    if (PCout) begin
      bus_s = pc_q;
    end else if (MDRout) begin
      bus_s = mdr_q;
    end else if (ZHighout) begin
      bus_s = z_q[63:32];
    end else if (ZLowout) begin
      bus_s = z_q[31:0];
    end else if (HIout) begin
      bus_s = hi_q;
    end else if (LOout) begin
      bus_s = lo_q;
    end else if (InPortout) begin
      bus_s = inport_q;
    end else if (Cout) begin
      bus_s = csext_s;
    end else if (Yout) begin
      bus_s = y_q;
    end else if (R_out || BAout) begin
      bus_s = rf_rd_s;
    end else begin
      bus_s = 32'd0;
    end
  end

  // Rotates come from shifting a doubled copy of A, which also gives the
  // correct result for a zero shift amount.
  assign shamt_s    = bus_s[4:0];
  assign dbl_s      = {y_q, y_q};
  assign ror_full_s = dbl_s >> shamt_s;
  assign rol_full_s = dbl_s << shamt_s;
  assign sra_s      = $signed(y_q) >>> shamt_s;
  assign mul_s      = $signed({{32{y_q[31]}}, y_q}) * $signed({{32{bus_s[31]}}, bus_s});

  // Signed divide; a zero divisor yields zero quotient and remainder.
  always_comb begin
    quo_s = 32'd0;
    rem_s = 32'd0;
    if (bus_s != 32'd0) begin
      quo_s = $signed(y_q) / $signed(bus_s);
      rem_s = $signed(y_q) % $signed(bus_s);
    end else begin
      quo_s = 32'd0;
      rem_s = 32'd0;
    end
  end

  // ALU result selection (A = Y, B = bus). Only MUL and DIV produce a high word.
  always_comb begin
    z_d = 64'd0;
    if (IncPC) begin
      z_d = {32'd0, bus_s + 32'd1};
    end else begin
      case (opCode)
        OP_ADD:  z_d = {32'd0, y_q + bus_s + {31'd0, Cin}};
        OP_SUB:  z_d = {32'd0, y_q - bus_s};
        OP_AND:  z_d = {32'd0, y_q & bus_s};
        OP_OR:   z_d = {32'd0, y_q | bus_s};
        OP_SHR:  z_d = {32'd0, y_q >> shamt_s};
        OP_SHRA: z_d = {32'd0, sra_s};
        OP_SHL:  z_d = {32'd0, y_q << shamt_s};
        OP_ROR:  z_d = {32'd0, ror_full_s[31:0]};
        OP_ROL:  z_d = {32'd0, rol_full_s[63:32]};
        OP_MUL:  z_d = mul_s;
        OP_DIV:  z_d = {rem_s, quo_s};
        OP_NEG:  z_d = {32'd0, 32'd0 - bus_s};
        OP_NOT:  z_d = {32'd0, ~bus_s};
        default: z_d = {32'd0, y_q + bus_s};
      endcase
    end
  end

  // Branch condition from IR[20:19] evaluated on the bus value.
  always_comb begin
    con_d = 1'b0;
    case (ir_q[20:19])
      2'b00:   con_d = (bus_s == 32'd0);
      2'b01:   con_d = (bus_s != 32'd0);
      2'b10:   con_d = ~bus_s[31];
      2'b11:   con_d = bus_s[31];
      default: con_d = 1'b0;
    endcase
  end

  // MDR source: memory read data or the bus.
  always_comb begin
    mdr_d = bus_s;
    if (MDR_read) begin
      mdr_d = mem_rd_s;
    end else begin
      mdr_d = bus_s;
    end
  end

`ifdef DATAPATH_RAM_EN
  // RAM is not touched by clr; contents start at zero and survive resets.
  logic [31:0] ram_q [512] = '{default: 32'd0};

  assign mem_rd_s = ram_q[mar_q];

  // RAM write port; a write coinciding with clr is dropped.
  always_ff @(posedge clk) begin
    if (RAM_write && !clr) begin
      ram_q[mar_q] <= mdr_q;
    end
  end

  assign unused_bits_s = ^{ir_q[31:27], Mdatain, ror_full_s[63:32], rol_full_s[31:0]};
`else
  assign mem_rd_s      = Mdatain;
  assign unused_bits_s = ^{ir_q[31:27], RAM_write, mar_q, ror_full_s[63:32], rol_full_s[31:0]};
`endif

  // Special-purpose registers loaded from the bus.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_q      <= 32'd0;
      ir_q      <= 32'd0;
      y_q       <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      mar_q     <= 9'd0;
      outport_q <= 32'd0;
    end else begin
      if (PC_enable)      pc_q      <= bus_s;
      if (IR_enable)      ir_q      <= bus_s;
      if (Y_enable)       y_q       <= bus_s;
      if (HI_enable)      hi_q      <= bus_s;
      if (LO_enable)      lo_q      <= bus_s;
      if (MAR_enable)     mar_q     <= bus_s[8:0];
      if (OutPort_enable) outport_q <= bus_s;
    end
  end

  // Z, MDR, CON and the free-running input-port sampler.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      z_q      <= 64'd0;
      mdr_q    <= 32'd0;
      con_q    <= 1'b0;
      inport_q <= 32'd0;
    end else begin
      if (ZHighIn)    z_q[63:32] <= z_d[63:32];
      if (ZLowIn)     z_q[31:0]  <= z_d[31:0];
      if (MDR_enable) mdr_q      <= mdr_d;
      if (CONin)      con_q      <= con_d;
      inport_q <= InPort_input;
    end
  end

  // General-purpose register file R0-R15.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= 32'd0;
      end
    end else begin
      if (R_in) rf_q[rsel_s] <= bus_s;
    end
  end

  assign OutPort_output = outport_q;
  assign branch_flag    = con_q;

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] OutPort_output;
  logic        branch_flag;
  logic        IncPC, CONin;
  logic [31:0] Mdatain;
  logic [4:0]  opCode;
  logic        RAM_write, MDR_enable, MDRout, MAR_enable, IR_enable, MDR_read;
  logic        Gra, Grb, Grc;
  logic        HI_enable, LO_enable, ZHighIn, ZLowIn, Y_enable, PC_enable, OutPort_enable;
  logic        InPortout, PCout, Yout, ZLowout, ZHighout, LOout, HIout, BAout, Cout;
  logic [31:0] InPort_input;
  logic        R_in, R_out, Cin;

  always #5 clk = ~clk;

  datapath dut (
    .clk(clk), .clr(clr), .OutPort_output(OutPort_output), .branch_flag(branch_flag),
    .IncPC(IncPC), .CONin(CONin), .Mdatain(Mdatain), .opCode(opCode),
    .RAM_write(RAM_write), .MDR_enable(MDR_enable), .MDRout(MDRout),
    .MAR_enable(MAR_enable), .IR_enable(IR_enable), .MDR_read(MDR_read),
    .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .HI_enable(HI_enable), .LO_enable(LO_enable), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
    .Y_enable(Y_enable), .PC_enable(PC_enable), .OutPort_enable(OutPort_enable),
    .InPortout(InPortout), .PCout(PCout), .Yout(Yout), .ZLowout(ZLowout),
    .ZHighout(ZHighout), .LOout(LOout), .HIout(HIout), .BAout(BAout), .Cout(Cout),
    .InPort_input(InPort_input), .R_in(R_in), .R_out(R_out), .Cin(Cin)
  );

`ifdef DATAPATH_RAM_EN
  localparam bit RAM_EN = 1'b1;
`else
  localparam bit RAM_EN = 1'b0;
`endif

  // load targets
  localparam int T_PC = 0, T_IR = 1, T_Y = 2, T_HI = 3, T_LO = 4, T_MAR = 5, T_MDR = 6, T_OUT = 7, T_R = 8;
  // observe sources
  localparam int S_NONE = 0, S_PC = 1, S_MDR = 2, S_ZH = 3, S_ZL = 4, S_HI = 5, S_LO = 6,
                 S_IN = 7, S_C = 8, S_Y = 9, S_RA = 10, S_BA = 11;

  typedef struct {
    string       tag;
    logic [31:0] val;
    bit          flag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IncPC = 1'b0; CONin = 1'b0; opCode = 5'd0; RAM_write = 1'b0; MDR_enable = 1'b0;
    MDRout = 1'b0; MAR_enable = 1'b0; IR_enable = 1'b0; MDR_read = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; HI_enable = 1'b0; LO_enable = 1'b0;
    ZHighIn = 1'b0; ZLowIn = 1'b0; Y_enable = 1'b0; PC_enable = 1'b0; OutPort_enable = 1'b0;
    InPortout = 1'b0; PCout = 1'b0; Yout = 1'b0; ZLowout = 1'b0; ZHighout = 1'b0;
    LOout = 1'b0; HIout = 1'b0; BAout = 1'b0; Cout = 1'b0; R_in = 1'b0; R_out = 1'b0; Cin = 1'b0;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v, input bit flag);
    exp_t e;
    e.tag = tag; e.val = v; e.flag = flag;
    sb_q.push_back(e);
  endtask

  // Pop every pending expectation and compare against the DUT outputs.
  task automatic drain();
    exp_t        e;
    logic [31:0] obs_v;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      obs_v = e.flag ? {31'd0, branch_flag} : OutPort_output;
      checks++;
      assert (obs_v === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs_v, e.val);
      end
    end
  endtask

  // Put a value on the bus via the input port (one edge to sample it).
  task automatic src(input logic [31:0] v);
    InPort_input = v;
    tick();
    InPortout = 1'b1;
  endtask

  task automatic load(input logic [31:0] v, input int tgt);
    src(v);
    case (tgt)
      T_PC:  PC_enable = 1'b1;
      T_IR:  IR_enable = 1'b1;
      T_Y:   Y_enable = 1'b1;
      T_HI:  HI_enable = 1'b1;
      T_LO:  LO_enable = 1'b1;
      T_MAR: MAR_enable = 1'b1;
      T_MDR: MDR_enable = 1'b1;
      T_OUT: OutPort_enable = 1'b1;
      T_R:   begin Gra = 1'b1; R_in = 1'b1; end
      default: ;
    endcase
    tick();
    idle();
  endtask

  // Route a source into the output port and check it (extra sources may be preset).
  task automatic obs(input string tag, input int s, input logic [31:0] exp_v);
    case (s)
      S_PC:  PCout = 1'b1;
      S_MDR: MDRout = 1'b1;
      S_ZH:  ZHighout = 1'b1;
      S_ZL:  ZLowout = 1'b1;
      S_HI:  HIout = 1'b1;
      S_LO:  LOout = 1'b1;
      S_IN:  InPortout = 1'b1;
      S_C:   Cout = 1'b1;
      S_Y:   Yout = 1'b1;
      S_RA:  begin Gra = 1'b1; R_out = 1'b1; end
      S_BA:  begin Gra = 1'b1; BAout = 1'b1; end
      default: ;
    endcase
    OutPort_enable = 1'b1;
    push_exp(tag, exp_v, 1'b0);
    tick();
    idle();
    drain();
  endtask

  task automatic con_chk(input string tag, input logic exp_f);
    Gra = 1'b1; R_out = 1'b1; CONin = 1'b1;
    push_exp(tag, {31'd0, exp_f}, 1'b1);
    tick();
    idle();
    drain();
  endtask

  task automatic alu_case(input string tag, input logic [4:0] op, input logic [31:0] b,
                          input logic cin, input logic inc, input logic [31:0] lo, input logic [31:0] hi);
    src(b);
    opCode = op; Cin = cin; IncPC = inc; ZHighIn = 1'b1; ZLowIn = 1'b1;
    tick();
    idle();
    obs({tag, "_lo"}, S_ZL, lo);
    obs({tag, "_hi"}, S_ZH, hi);
  endtask

  initial begin
    idle();
    InPort_input = 32'd0;
    Mdatain = 32'd0;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    push_exp("rst_out", 32'd0, 1'b0);
    push_exp("rst_flag", 32'd0, 1'b1);
    drain();

    // Load everything, then pulse clr between edges
    load(32'h9A980000, T_IR);
    load(32'h11111111, T_PC);
    load(32'h22222222, T_Y);
    load(32'h33333333, T_HI);
    load(32'h44444444, T_LO);
    load(32'hDEADBEEF, T_R);
    load(32'h66666666, T_MDR);
    src(32'h01010101);
    opCode = 5'b00011; ZHighIn = 1'b1; ZLowIn = 1'b1;
    tick();
    idle();
    con_chk("con_pre_clr", 1'b1);
    load(32'h77777777, T_OUT);
    #2 clr = 1'b1;
    #1;
    push_exp("clr_out_async", 32'd0, 1'b0);
    push_exp("clr_flag_async", 32'd0, 1'b1);
    drain();
    #1 clr = 1'b0;
    InPort_input = 32'd0;
    obs("clr_pc", S_PC, 32'd0);
    obs("clr_mdr", S_MDR, 32'd0);
    obs("clr_zh", S_ZH, 32'd0);
    obs("clr_zl", S_ZL, 32'd0);
    obs("clr_hi", S_HI, 32'd0);
    obs("clr_lo", S_LO, 32'd0);
    obs("clr_y", S_Y, 32'd0);
    load(32'h9A980000, T_IR);
    obs("clr_r5", S_RA, 32'd0);

    // Fetch
    load(32'd5, T_PC);
    PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
    tick();
    idle();
    ZLowout = 1'b1; PC_enable = 1'b1;
    tick();
    idle();
    obs("fetch_pc", S_PC, 32'd6);
    obs("fetch_zl", S_ZL, 32'd6);
    Mdatain = 32'h0000AAAA; MDR_read = 1'b1; MDR_enable = 1'b1;
    tick();
    idle();
    obs("fetch_mar_rd", S_MDR, RAM_EN ? 32'd0 : 32'h0000AAAA);

    // ALU
    load(32'd7, T_Y);
    alu_case("mul_7_m3", 5'b01110, 32'hFFFFFFFD, 1'b0, 1'b0, 32'hFFFFFFEB, 32'hFFFFFFFF);
    alu_case("div_7_m3", 5'b01111, 32'hFFFFFFFD, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000001);
    load(32'h80000011, T_Y);
    alu_case("add_cin1", 5'b00011, 32'd4, 1'b1, 1'b0, 32'h80000016, 32'd0);
    alu_case("add_cin0", 5'b00011, 32'd4, 1'b0, 1'b0, 32'h80000015, 32'd0);
    alu_case("sub",      5'b00100, 32'd4, 1'b1, 1'b0, 32'h8000000D, 32'd0);
    alu_case("and",      5'b00101, 32'd4, 1'b1, 1'b0, 32'h00000000, 32'd0);
    alu_case("or",       5'b00110, 32'd4, 1'b1, 1'b0, 32'h80000015, 32'd0);
    alu_case("shr",      5'b00111, 32'd4, 1'b1, 1'b0, 32'h08000001, 32'd0);
    alu_case("shr_b40",  5'b00111, 32'h24, 1'b0, 1'b0, 32'h08000001, 32'd0);
    alu_case("shra",     5'b01000, 32'd4, 1'b1, 1'b0, 32'hF8000001, 32'd0);
    alu_case("shl",      5'b01001, 32'd4, 1'b1, 1'b0, 32'h00000110, 32'd0);
    alu_case("ror",      5'b01010, 32'd4, 1'b1, 1'b0, 32'h18000001, 32'd0);
    alu_case("rol",      5'b01011, 32'd4, 1'b1, 1'b0, 32'h00000118, 32'd0);
    alu_case("mul_neg",  5'b01110, 32'd4, 1'b0, 1'b0, 32'h00000044, 32'hFFFFFFFE);
    alu_case("div_neg",  5'b01111, 32'd4, 1'b0, 1'b0, 32'hE0000005, 32'hFFFFFFFD);
    alu_case("div_zero", 5'b01111, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    alu_case("neg",      5'b10000, 32'd4, 1'b1, 1'b0, 32'hFFFFFFFC, 32'd0);
    alu_case("not",      5'b10001, 32'd4, 1'b1, 1'b0, 32'hFFFFFFFB, 32'd0);
    alu_case("dflt_add", 5'b00000, 32'd4, 1'b0, 1'b0, 32'h80000015, 32'd0);
    alu_case("incpc",    5'b01110, 32'h7FFFFFFF, 1'b1, 1'b1, 32'h80000000, 32'd0);

    // Branch conditions
    load(32'h9A980000, T_IR);
    load(32'h80000000, T_R);
    con_chk("br_c11_neg", 1'b1);
    load(32'd0, T_R);
    con_chk("br_c11_zero", 1'b0);
    load(32'h9A880000, T_IR);
    load(32'd1, T_R);
    con_chk("br_c01_nz", 1'b1);
    load(32'd0, T_R);
    con_chk("br_c01_z", 1'b0);
    load(32'h9A800000, T_IR);
    con_chk("br_c00_z", 1'b1);
    load(32'h9A900000, T_IR);
    load(32'h80000000, T_R);
    con_chk("br_c10_neg", 1'b0);

    // Memory
    Mdatain = 32'h12345678; MDR_read = 1'b1; MDR_enable = 1'b1;
    tick();
    idle();
    obs("mdr_read", S_MDR, RAM_EN ? 32'd0 : 32'h12345678);
    load(32'd3, T_MAR);
    load(32'hCAFEF00D, T_MDR);
    RAM_write = 1'b1;
    tick();
    idle();
    load(32'd0, T_MDR);
    MDR_read = 1'b1; MDR_enable = 1'b1;
    tick();
    idle();
    obs("ram_reload", S_MDR, RAM_EN ? 32'hCAFEF00D : 32'h12345678);

    // Bus priority and register selection
    load(32'h00000099, T_MDR);
    MDRout = 1'b1;
    obs("prio_pc_mdr", S_PC, 32'd6);
    load(32'h01000000, T_IR);
    load(32'h00000055, T_R);
    obs("r2_out", S_RA, 32'h55);
    Gra = 1'b1; R_out = 1'b1;
    obs("prio_y_r", S_Y, 32'h80000011);
    load(32'h000000A1, T_HI);
    load(32'h000000B2, T_LO);
    LOout = 1'b1;
    obs("prio_hi_lo", S_HI, 32'hA1);
    obs("lo_only", S_LO, 32'hB2);
    load(32'h00100000, T_IR);
    Grb = 1'b1; R_out = 1'b1;
    obs("grb_r2", S_NONE, 32'h55);
    obs("no_source", S_NONE, 32'd0);
    load(32'd0, T_IR);
    load(32'h00000077, T_R);
    obs("ba_r0_zero", S_BA, 32'd0);
    obs("r0_out", S_RA, 32'h77);
    load(32'h00040001, T_IR);
    obs("c_sext_neg", S_C, 32'hFFFC0001);
    load(32'h0003FFFF, T_IR);
    obs("c_sext_pos", S_C, 32'h0003FFFF);
    InPort_input = 32'h13572468;
    tick();
    Cout = 1'b1;
    obs("prio_in_c", S_IN, 32'h13572468);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
